// File: rtl/fir_pkg.sv
// Shared helpers for the parametrised FIR filter.
// Provides:
//   clog2         - ceiling log2 for elaboration-time sizing
//   prod_w        - width of one full-precision signed product
//   acc_w         - width of the non-overflowing tap-sum accumulator
//   impulse_coef  - reset value of tap k (centre tap 1, all others 0)
package fir_pkg;

   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      int unsigned v;
      r = 0;
      v = 1;
      while (v < n) begin
         v = v * 2;
         r = r + 1;
      end
      return r;
   endfunction

   function automatic int unsigned prod_w(input int unsigned data_w, input int unsigned coef_w);
      return data_w + coef_w;
   endfunction

   // Summing n products can grow the magnitude by at most a factor n.
   function automatic int unsigned acc_w(input int unsigned data_w, input int unsigned coef_w,
                                         input int unsigned ntaps);
      return data_w + coef_w + clog2(ntaps);
   endfunction

   function automatic int unsigned impulse_coef(input int unsigned k, input int unsigned ntaps);
      return (k == (ntaps - 1) / 2) ? 1 : 0;
   endfunction

endpackage

// File: rtl/fir_tap_mult.sv
// One FIR tap: registered full-precision signed multiply with a valid passthrough.
// Ports:
//   clk_i, rst_ni - clock, synchronous active-low reset
//   valid_i       - x_i holds a new delay-line sample this cycle
//   x_i, h_i      - signed sample and signed coefficient
//   valid_o, p_o  - registered valid and product (DATA_W+COEF_W bits)
module fir_tap_mult
   import fir_pkg::*;
#(
   parameter int unsigned DATA_W = 14,
   parameter int unsigned COEF_W = 8
) (
   input  logic                                     clk_i,
   input  logic                                     rst_ni,
   input  logic                                     valid_i,
   input  logic signed [DATA_W-1:0]                 x_i,
   input  logic signed [COEF_W-1:0]                 h_i,
   output logic                                     valid_o,
   output logic signed [prod_w(DATA_W, COEF_W)-1:0] p_o
);

   localparam int unsigned PW = prod_w(DATA_W, COEF_W);

   logic signed [PW-1:0] p_d, p_q;
   logic                 valid_q;

   assign p_d = PW'(x_i) * PW'(h_i);

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         p_q     <= '0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= valid_i;
         if (valid_i) begin
            p_q <= p_d;
         end
      end
   end

   assign p_o     = p_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/fir_param_filter.sv
// Parametrised streaming signed FIR filter with a shadow/active coefficient bank.
// Ports:
//   clk_i, rst_ni              - clock, synchronous active-low reset
//   din_i, din_valid_i         - signed input sample stream
//   coe_wr_i, coe_idx_i,
//   coe_data_i                 - indexed write into the shadow bank
//   coe_commit_i               - copy shadow bank into active bank (write bypassed in)
//   coe_err_o                  - pulse: previous write had an out-of-range index
//   dout_o, dout_valid_o       - rounded, shifted, saturated result stream
//   sat_o                      - pulse with dout_valid_o when the result was clipped
// Pipeline: S0 delay line -> S1 tap products -> S2 sum/round/saturate (latency 3).
module fir_param_filter
   import fir_pkg::*;
#(
   parameter int unsigned DATA_W = 14,
   parameter int unsigned COEF_W = 8,
   parameter int unsigned NTAPS  = 11,
   parameter int unsigned SHIFT  = 0,
   parameter int unsigned OUT_W  = 24,
   parameter int unsigned IDX_W  = 4
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic signed [DATA_W-1:0] din_i,
   input  logic                    din_valid_i,
   input  logic                    coe_wr_i,
   input  logic [IDX_W-1:0]        coe_idx_i,
   input  logic signed [COEF_W-1:0] coe_data_i,
   input  logic                    coe_commit_i,
   output logic                    coe_err_o,
   output logic signed [OUT_W-1:0] dout_o,
   output logic                    dout_valid_o,
   output logic                    sat_o
);

   localparam int unsigned PROD_W = prod_w(DATA_W, COEF_W);
   localparam int unsigned ACC_W  = acc_w(DATA_W, COEF_W, NTAPS);
   // One spare bit so adding the rounding constant cannot wrap.
   localparam int unsigned RW     = ACC_W + 1;
   localparam logic signed [RW-1:0] RoundK  = RW'((2 ** SHIFT) / 2);
   localparam logic [IDX_W:0]       NTapsIx = (IDX_W + 1)'(NTAPS);

   // ---------------- S0: delay line ----------------
   logic signed [DATA_W-1:0] x_q [NTAPS];
   logic                     v0_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int k = 0; k < NTAPS; k++) x_q[k] <= '0;
         v0_q <= 1'b0;
      end else begin
         v0_q <= din_valid_i;
         if (din_valid_i) begin
            x_q[0] <= din_i;
            for (int k = 1; k < NTAPS; k++) x_q[k] <= x_q[k-1];
         end
      end
   end

   // ---------------- Coefficient banks ----------------
   logic signed [COEF_W-1:0] shadow_d [NTAPS];
   logic signed [COEF_W-1:0] shadow_q [NTAPS];
   logic signed [COEF_W-1:0] active_q [NTAPS];
   logic                     wr_ok;
   logic                     coe_err_q;

   assign wr_ok = coe_wr_i && ({1'b0, coe_idx_i} < NTapsIx);

   always_comb begin
      for (int k = 0; k < NTAPS; k++) begin
         shadow_d[k] = (wr_ok && (coe_idx_i == IDX_W'(k))) ? coe_data_i : shadow_q[k];
      end
   end

   // Commit copies shadow_d, so a write in the commit cycle lands in the new bank.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int k = 0; k < NTAPS; k++) begin
            shadow_q[k] <= COEF_W'(impulse_coef(k, NTAPS));
            active_q[k] <= COEF_W'(impulse_coef(k, NTAPS));
         end
         coe_err_q <= 1'b0;
      end else begin
         shadow_q  <= shadow_d;
         if (coe_commit_i) begin
            active_q <= shadow_d;
         end
         coe_err_q <= coe_wr_i && !wr_ok;
      end
   end

   // ---------------- S1: tap products ----------------
   logic signed [PROD_W-1:0] p [NTAPS];
   logic [NTAPS-1:0]         v1;
   logic                     v1_all;

   for (genvar k = 0; k < NTAPS; k++) begin : g_tap
      fir_tap_mult #(
         .DATA_W (DATA_W),
         .COEF_W (COEF_W)
      ) u_tap (
         .clk_i   (clk_i),
         .rst_ni  (rst_ni),
         .valid_i (v0_q),
         .x_i     (x_q[k]),
         .h_i     (active_q[k]),
         .valid_o (v1[k]),
         .p_o     (p[k])
      );
   end

   // Every tap sees the same valid, so the per-tap copies are identical.
   assign v1_all = &v1;

   // ---------------- S2: sum, round, shift, saturate ----------------
   logic signed [ACC_W-1:0] acc;
   logic signed [RW-1:0]    rnd, shd;
   logic signed [OUT_W-1:0] dout_d, dout_q;
   logic                    clip;
   logic                    dout_valid_q, sat_q;

   always_comb begin
      acc = '0;
      for (int k = 0; k < NTAPS; k++) acc = acc + ACC_W'(p[k]);
   end

   assign rnd = RW'(acc) + RoundK;
   assign shd = rnd >>> SHIFT;

   if (OUT_W >= RW) begin : g_nosat
      assign dout_d = OUT_W'(shd);
      assign clip   = 1'b0;
   end else begin : g_sat
      // Fits iff all bits from the output sign bit upward agree.
      logic [RW-OUT_W:0] hi;
      assign hi     = shd[RW-1:OUT_W-1];
      assign clip   = !((&hi) || !(|hi));
      assign dout_d = !clip       ? shd[OUT_W-1:0]                  :
                      shd[RW-1]   ? {1'b1, {(OUT_W - 1){1'b0}}}     :
                                    {1'b0, {(OUT_W - 1){1'b1}}};
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         sat_q        <= 1'b0;
      end else begin
         dout_valid_q <= v1_all;
         sat_q        <= v1_all && clip;
         if (v1_all) begin
            dout_q <= dout_d;
         end
      end
   end

   assign dout_o       = dout_q;
   assign dout_valid_o = dout_valid_q;
   assign sat_o        = sat_q;
   assign coe_err_o    = coe_err_q;

endmodule
